// File: rtl/cache_ev_if.sv
// Event handshake between the LRU cache model (master) and the stats collector (slave).
interface cache_ev_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_kind;
    logic       ev_hit;
    logic       ev_evict;

    modport master (output ev_valid, ev_kind, ev_hit, ev_evict, input ev_ready);
    modport slave  (input ev_valid, ev_kind, ev_hit, ev_evict, output ev_ready);
endinterface

// File: rtl/cache_stats_collector.sv
// Accumulates per-event cache statistics for the VGA display path; freezes totals
// (endFile) once the trace is exhausted.
module cache_stats_collector #(
    parameter int CW  = 32,
    parameter bit SAT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          trace_done,
    cache_ev_if.slave     ev,
    output logic          endFile,
    output logic          proto_err,
    output logic [CW-1:0] accessesTotal,
    output logic [CW-1:0] evictionTotal,
    output logic [CW-1:0] writeHitTotal,
    output logic [CW-1:0] readHitTotal,
    output logic [CW-1:0] writeMissTotal,
    output logic [CW-1:0] readMissTotal,
    output logic [CW-1:0] instTotal,
    output logic [CW-1:0] hitTotal,
    output logic [CW-1:0] missTotal
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int ACC = 0, EVI = 1, WH = 2, RH = 3, WM = 4, RM = 5, INST = 6, HIT = 7, MISS = 8;
    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t              state, state_nxt;
    logic [8:0][CW-1:0]  tot;
    logic [8:0]          bump;
    logic                set_err;
    logic                accept;

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
        if (SAT && (&v)) return v;
        return v + ONE;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        ev.ev_ready = (state == RUN);
        endFile     = (state == DONE);
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (start) state_nxt = RUN;
                     else if (trace_done) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // start in the same cycle as an event wins: the event is dropped with the clear
    assign accept = (state == RUN) && ev.ev_valid && !start;

    always_comb begin
        bump    = '0;
        set_err = 1'b0;
        if (accept) begin
            unique case (ev.ev_kind)
                2'b00, 2'b01: begin
                    bump[INST] = 1'b1;
                    bump[ACC]  = 1'b1;
                    if (ev.ev_hit) begin
                        bump[HIT]                       = 1'b1;
                        bump[ev.ev_kind[0] ? WH : RH]   = 1'b1;
                        set_err                         = ev.ev_evict;
                    end else begin
                        bump[MISS]                      = 1'b1;
                        bump[ev.ev_kind[0] ? WM : RM]   = 1'b1;
                        bump[EVI]                       = ev.ev_evict;
                    end
                end
                2'b10:   bump[INST] = 1'b1;
                default: set_err    = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            tot       <= '0;
            proto_err <= 1'b0;
        end else begin
            for (int i = 0; i < 9; i++)
                if (bump[i]) tot[i] <= inc(tot[i]);
            if (set_err) proto_err <= 1'b1;
        end
    end

    assign accessesTotal  = tot[ACC];
    assign evictionTotal  = tot[EVI];
    assign writeHitTotal  = tot[WH];
    assign readHitTotal   = tot[RH];
    assign writeMissTotal = tot[WM];
    assign readMissTotal  = tot[RM];
    assign instTotal      = tot[INST];
    assign hitTotal       = tot[HIT];
    assign missTotal      = tot[MISS];
endmodule

// File: tb/tb_cache_stats_collector.sv
// Three collectors (32-bit sat, 4-bit sat, 4-bit wrap) share stimulus; an unbounded
// count model projected to each width/mode is compared every cycle.
module tb_cache_stats_collector;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, start = 1'b0, trace_done = 1'b0;
    logic       ev_valid = 1'b0, ev_hit = 1'b0, ev_evict = 1'b0;
    logic [1:0] ev_kind = 2'b00;

    cache_ev_if i0 ();
    cache_ev_if i1 ();
    cache_ev_if i2 ();
    assign i0.ev_valid = ev_valid; assign i0.ev_kind = ev_kind; assign i0.ev_hit = ev_hit; assign i0.ev_evict = ev_evict;
    assign i1.ev_valid = ev_valid; assign i1.ev_kind = ev_kind; assign i1.ev_hit = ev_hit; assign i1.ev_evict = ev_evict;
    assign i2.ev_valid = ev_valid; assign i2.ev_kind = ev_kind; assign i2.ev_hit = ev_hit; assign i2.ev_evict = ev_evict;

    logic [31:0] t0 [9];
    logic [3:0]  t1 [9];
    logic [3:0]  t2 [9];
    logic [2:0]  ef, pe;

    cache_stats_collector #(.CW(32), .SAT(1'b1)) dut0 (
        .clk(clk), .reset(rst), .start(start), .trace_done(trace_done), .ev(i0.slave),
        .endFile(ef[0]), .proto_err(pe[0]),
        .accessesTotal(t0[0]), .evictionTotal(t0[1]), .writeHitTotal(t0[2]), .readHitTotal(t0[3]),
        .writeMissTotal(t0[4]), .readMissTotal(t0[5]), .instTotal(t0[6]), .hitTotal(t0[7]), .missTotal(t0[8]));
    cache_stats_collector #(.CW(4), .SAT(1'b1)) dut1 (
        .clk(clk), .reset(rst), .start(start), .trace_done(trace_done), .ev(i1.slave),
        .endFile(ef[1]), .proto_err(pe[1]),
        .accessesTotal(t1[0]), .evictionTotal(t1[1]), .writeHitTotal(t1[2]), .readHitTotal(t1[3]),
        .writeMissTotal(t1[4]), .readMissTotal(t1[5]), .instTotal(t1[6]), .hitTotal(t1[7]), .missTotal(t1[8]));
    cache_stats_collector #(.CW(4), .SAT(1'b0)) dut2 (
        .clk(clk), .reset(rst), .start(start), .trace_done(trace_done), .ev(i2.slave),
        .endFile(ef[2]), .proto_err(pe[2]),
        .accessesTotal(t2[0]), .evictionTotal(t2[1]), .writeHitTotal(t2[2]), .readHitTotal(t2[3]),
        .writeMissTotal(t2[4]), .readMissTotal(t2[5]), .instTotal(t2[6]), .hitTotal(t2[7]), .missTotal(t2[8]));

    string nm [9] = '{"acc", "evict", "wh", "rh", "wm", "rm", "inst", "hit", "miss"};

    int n_vec = 0, n_bad = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input longint unsigned act, input longint unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: exact event counts, later projected onto each counter width.
    int              m_mode = 0;  // 0 idle, 1 running, 2 finished
    longint unsigned cnt [9];
    bit              m_err = 1'b0;

    function automatic longint unsigned proj(input longint unsigned c, input int cw, input bit sat);
        longint unsigned mx = (64'd1 << cw) - 1;
        if (sat) return (c > mx) ? mx : c;
        return c & mx;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_err = 1'b0;
            foreach (cnt[i]) cnt[i] = 0;
        end else if (start) begin
            m_mode = 1; m_err = 1'b0;
            foreach (cnt[i]) cnt[i] = 0;
        end else if (m_mode == 1) begin
            if (ev_valid) begin
                if (ev_kind == 2'b11) m_err = 1'b1;
                else begin
                    cnt[6]++;
                    if (ev_kind != 2'b10) begin
                        cnt[0]++;
                        if (ev_hit) begin
                            cnt[7]++;
                            if (ev_kind == 2'b00) cnt[3]++; else cnt[2]++;
                            if (ev_evict) m_err = 1'b1;
                        end else begin
                            cnt[8]++;
                            if (ev_kind == 2'b00) cnt[5]++; else cnt[4]++;
                            if (ev_evict) cnt[1]++;
                        end
                    end
                end
            end
            if (trace_done) m_mode = 2;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 9; i++) begin
                cmp({"d0_", nm[i]}, t0[i], proj(cnt[i], 32, 1'b1));
                cmp({"d1_", nm[i]}, t1[i], proj(cnt[i], 4, 1'b1));
                cmp({"d2_", nm[i]}, t2[i], proj(cnt[i], 4, 1'b0));
            end
            cmp("d0_ready", i0.ev_ready, m_mode == 1);
            cmp("d1_ready", i1.ev_ready, m_mode == 1);
            cmp("d2_ready", i2.ev_ready, m_mode == 1);
            for (int d = 0; d < 3; d++) begin
                cmp($sformatf("d%0d_endFile", d), ef[d], m_mode == 2);
                cmp($sformatf("d%0d_proto_err", d), pe[d], m_err);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic ev(input logic [1:0] k, input logic h, input logic e);
        ev_valid = 1'b1; ev_kind = k; ev_hit = h; ev_evict = e;
        step();
        ev_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    initial begin
        step(2);
        chk_en = 1'b1;
        cmp("rst_acc", t0[0], 0); cmp("rst_endFile", ef[0], 0);
        cmp("rst_ready", i0.ev_ready, 0); cmp("rst_perr", pe[0], 0);
        rst = 1'b0;

        // four classified accesses
        pulse_start();
        ev(2'b00, 1'b1, 1'b0); ev(2'b00, 1'b0, 1'b1); ev(2'b01, 1'b1, 1'b0); ev(2'b01, 1'b0, 1'b0);
        cmp("t1_acc", t0[0], 4); cmp("t1_rh", t0[3], 1); cmp("t1_rm", t0[5], 1);
        cmp("t1_wh", t0[2], 1); cmp("t1_wm", t0[4], 1); cmp("t1_hit", t0[7], 2);
        cmp("t1_miss", t0[8], 2); cmp("t1_evict", t0[1], 1); cmp("t1_inst", t0[6], 4);
        cmp("t1_perr", pe[0], 0);

        // instruction-only events then trace end; DONE ignores traffic
        pulse_start();
        repeat (3) ev(2'b10, 1'b1, 1'b1);
        trace_done = 1'b1; step(); trace_done = 1'b0;
        cmp("t2_inst", t0[6], 3); cmp("t2_acc", t0[0], 0);
        cmp("t2_endFile", ef[0], 1); cmp("t2_ready", i0.ev_ready, 0);
        repeat (3) ev(2'b00, 1'b0, 1'b0);
        cmp("t2_inst_hold", t0[6], 3); cmp("t2_acc_hold", t0[0], 0);

        // final event coincident with trace end, then restart
        pulse_start();
        ev_valid = 1'b1; ev_kind = 2'b00; ev_hit = 1'b0; ev_evict = 1'b0; trace_done = 1'b1;
        step();
        ev_valid = 1'b0; trace_done = 1'b0;
        cmp("t3_rm", t0[5], 1); cmp("t3_endFile", ef[0], 1);
        pulse_start();
        cmp("t3_rm_clr", t0[5], 0); cmp("t3_endFile_clr", ef[0], 0); cmp("t3_ready", i0.ev_ready, 1);

        // protocol errors
        ev(2'b11, 1'b0, 1'b0); ev(2'b00, 1'b1, 1'b1);
        cmp("t4_acc", t0[0], 1); cmp("t4_rh", t0[3], 1); cmp("t4_evict", t0[1], 0); cmp("t4_perr", pe[0], 1);
        step(2);
        cmp("t4_perr_sticky", pe[0], 1);
        pulse_start();
        cmp("t4_perr_clr", pe[0], 0);

        // 4-bit saturate vs wrap
        repeat (17) ev(2'b00, 1'b1, 1'b0);
        cmp("t5_sat_rh", t1[3], 15); cmp("t5_sat_hit", t1[7], 15);
        cmp("t5_sat_acc", t1[0], 15); cmp("t5_sat_inst", t1[6], 15);
        cmp("t5_wrap_rh", t2[3], 1); cmp("t5_wide_rh", t0[3], 17);

        // reset mid-run with traffic present
        ev_valid = 1'b1; ev_kind = 2'b01; ev_hit = 1'b0;
        step(2);
        rst = 1'b1; step(); rst = 1'b0;
        step(3);
        ev_valid = 1'b0;
        cmp("t6_acc", t0[0], 0); cmp("t6_ready", i0.ev_ready, 0); cmp("t6_wm", t1[4], 0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            start      = ($urandom_range(31) == 0);
            trace_done = ($urandom_range(23) == 0);
            rst        = ($urandom_range(199) == 0);
            ev_valid   = ($urandom_range(3) != 0);
            ev_kind    = 2'($urandom_range(3));
            ev_hit     = 1'($urandom_range(1));
            ev_evict   = ($urandom_range(3) == 0);
            step();
        end
        start = 1'b0; trace_done = 1'b0; rst = 1'b0; ev_valid = 1'b0;
        step(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
